// File: rtl/inst_fetcher.sv
// Instruction fetch stage: owns the PC, looks up the I-cache combinationally,
// refills it from the memory controller on a miss, and feeds the decoder.
module inst_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic [31:0] flush_pc,
    output logic [31:0] cache_addr,
    input  logic        cache_hit,
    input  logic [31:0] cache_data,
    output logic        cache_upd,
    output logic [31:0] cache_upd_addr,
    output logic [31:0] cache_upd_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        MISS   = 2'd1,
        REFILL = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        slot_free;
    logic        slot_drain;
    logic [31:0] pc_step;

    assign cache_addr = pc;
    assign slot_free  = !inst_valid || inst_ready;
    assign slot_drain = inst_valid && inst_ready;
    // Full 32-bit encodings have both low bits set; everything else is RVC.
    assign pc_step    = (cache_data[1:0] == 2'b11) ? 32'd4 : 32'd2;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            inst_valid     <= 1'b0;
            inst_out       <= 32'h0;
            inst_pc        <= 32'h0;
            mem_req        <= 1'b0;
            mem_addr       <= 32'h0;
            cache_upd      <= 1'b0;
            cache_upd_addr <= 32'h0;
            cache_upd_data <= 32'h0;
        end else if (rdy_in) begin
            cache_upd <= 1'b0;
            if (slot_drain) begin
                inst_valid <= 1'b0;
            end

            case (state)
                FETCH: begin
                    // A redirect on this edge makes the current lookup stale.
                    if (!flush_in) begin
                        if (cache_hit) begin
                            if (slot_free) begin
                                inst_out   <= cache_data;
                                inst_pc    <= pc;
                                inst_valid <= 1'b1;
                                pc         <= pc + pc_step;
                            end
                        end else begin
                            mem_addr <= pc;
                            mem_req  <= 1'b1;
                            state    <= MISS;
                        end
                    end
                end
                MISS: begin
                    // The request runs to completion even across a redirect.
                    if (mem_done) begin
                        mem_req        <= 1'b0;
                        cache_upd      <= 1'b1;
                        cache_upd_addr <= mem_addr;
                        cache_upd_data <= mem_data;
                        state          <= REFILL;
                    end
                end
                REFILL: begin
                    state <= FETCH;
                end
                default: begin
                    state <= FETCH;
                end
            endcase

            if (flush_in) begin
                pc         <= flush_pc;
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher with a behavioural halfword-addressed cache
// and a fixed-latency memory responder.
module tb_inst_fetcher;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic [31:0] flush_pc;
    logic [31:0] cache_addr;
    logic        cache_hit;
    logic [31:0] cache_data;
    logic        cache_upd;
    logic [31:0] cache_upd_addr;
    logic [31:0] cache_upd_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready;

    inst_fetcher #(.RESET_PC(32'h0)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_in      (flush_in),
        .flush_pc      (flush_pc),
        .cache_addr    (cache_addr),
        .cache_hit     (cache_hit),
        .cache_data    (cache_data),
        .cache_upd     (cache_upd),
        .cache_upd_addr(cache_upd_addr),
        .cache_upd_data(cache_upd_data),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_done      (mem_done),
        .mem_data      (mem_data),
        .inst_valid    (inst_valid),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic [31:0] cache_mem [logic [31:0]];
    logic [31:0] mem_words [logic [31:0]];
    int          mem_lat;
    int          lat_cnt;
    int          upd_cnt;
    logic        seen_pc40;
    int          n_checks;
    int          n_fail;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_words.exists(a) != 0) return mem_words[a];
        return 32'h0000_0013;
    endfunction

    // Compressed-style marker word for the stream region: low bits 01.
    function automatic logic [31:0] rvc_word(input logic [31:0] a);
        return {16'h0, a[13:0], 2'b01};
    endfunction

    // Environment: memory responder, cache write port, cache lookup.
    initial begin
        mem_done  = 1'b0;
        mem_data  = 32'h0;
        cache_hit = 1'b0;
        cache_data = 32'h0;
        lat_cnt   = 0;
        upd_cnt   = 0;
        seen_pc40 = 1'b0;
        forever begin
            @(negedge clk_in);
            mem_done = 1'b0;
            if (!rst_in) begin
                lat_cnt = 0;
            end else if (rdy_in) begin
                if (cache_upd) begin
                    cache_mem[cache_upd_addr] = cache_upd_data;
                    upd_cnt++;
                end
                if (mem_req) begin
                    lat_cnt++;
                    if (lat_cnt >= mem_lat) begin
                        mem_done = 1'b1;
                        mem_data = mem_word(mem_addr);
                        lat_cnt  = 0;
                    end
                end else begin
                    lat_cnt = 0;
                end
            end
            cache_hit  = (cache_mem.exists(cache_addr) != 0);
            cache_data = cache_hit ? cache_mem[cache_addr] : 32'h0;
            if (inst_valid && inst_pc == 32'h40) seen_pc40 = 1'b1;
        end
    end

    task automatic step();
        @(negedge clk_in);
        #2;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40 && !inst_valid; i++) step();
        check_value(tag, {31'h0, inst_valid}, 32'h1);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        mem_lat    = 5;
        rst_in     = 1'b0;
        rdy_in     = 1'b1;
        flush_in   = 1'b0;
        flush_pc   = 32'h0;
        inst_ready = 1'b1;
        mem_words[32'h0] = 32'h00A0_0093;

        // Reset held: nothing requested, nothing issued.
        for (int i = 0; i < 3; i++) begin
            step();
            check_value("rst_mem_req", {31'h0, mem_req}, 32'h0);
        end
        check_value("rst_valid", {31'h0, inst_valid}, 32'h0);
        check_value("rst_pc", cache_addr, 32'h0);
        check_value("rst_upd", {31'h0, cache_upd}, 32'h0);

        // Cold miss at 0.
        rst_in = 1'b1;
        step();
        check_value("miss0_req", {31'h0, mem_req}, 32'h1);
        check_value("miss0_addr", mem_addr, 32'h0);
        for (int i = 0; i < 40 && !mem_done; i++) step();
        check_value("miss0_done_seen", {31'h0, mem_done}, 32'h1);
        check_value("miss0_valid_before", {31'h0, inst_valid}, 32'h0);
        step();
        check_value("refill0_upd", {31'h0, cache_upd}, 32'h1);
        check_value("refill0_addr", cache_upd_addr, 32'h0);
        check_value("refill0_data", cache_upd_data, 32'h00A0_0093);
        check_value("refill0_req_low", {31'h0, mem_req}, 32'h0);
        step();
        check_value("refill0_upd_once", {31'h0, cache_upd}, 32'h0);
        check_value("refill0_valid_c2", {31'h0, inst_valid}, 32'h0);
        step();
        check_value("miss0_valid_c3", {31'h0, inst_valid}, 32'h1);
        check_value("miss0_inst", inst_out, 32'h00A0_0093);
        check_value("miss0_pc", inst_pc, 32'h0);
        check_value("miss0_next_pc", cache_addr, 32'h4);
        check_value("miss0_upd_count", upd_cnt, 1);

        // Compressed then full instruction at 0x10.
        cache_mem[32'h10] = 32'h0013_4501;
        cache_mem[32'h12] = 32'h0000_0013;
        flush_in = 1'b1;
        flush_pc = 32'h10;
        step();
        flush_in = 1'b0;
        check_value("flush10_pc", cache_addr, 32'h10);
        check_value("flush10_valid", {31'h0, inst_valid}, 32'h0);
        wait_valid("hit10_timeout");
        check_value("hit10_pc", inst_pc, 32'h10);
        check_value("hit10_inst", inst_out, 32'h0013_4501);
        step();
        check_value("hit12_pc", inst_pc, 32'h12);
        check_value("hit12_inst", inst_out, 32'h0000_0013);
        check_value("hit12_next_pc", cache_addr, 32'h16);

        // Decoder back-pressure over a compressed stream at 0x20.
        for (int a = 32'h20; a <= 32'h3e; a += 2) cache_mem[a] = rvc_word(a);
        inst_ready = 1'b0;
        flush_in   = 1'b1;
        flush_pc   = 32'h20;
        step();
        flush_in = 1'b0;
        wait_valid("stall_timeout");
        check_value("stall_first_pc", inst_pc, 32'h20);
        for (int i = 0; i < 3; i++) begin
            step();
            check_value("stall_pc", inst_pc, 32'h20);
            check_value("stall_inst", inst_out, rvc_word(32'h20));
            check_value("stall_fetch_pc", cache_addr, 32'h22);
        end
        inst_ready = 1'b1;
        for (int a = 32'h22; a <= 32'h26; a += 2) begin
            step();
            check_value("resume_pc", inst_pc, a);
            check_value("resume_inst", inst_out, rvc_word(a));
            check_value("resume_valid", {31'h0, inst_valid}, 32'h1);
        end

        // Global freeze.
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_value("frz_pc", inst_pc, 32'h26);
            check_value("frz_valid", {31'h0, inst_valid}, 32'h1);
            check_value("frz_fetch_pc", cache_addr, 32'h28);
        end
        rdy_in = 1'b1;
        step();
        check_value("unfrz_pc28", inst_pc, 32'h28);
        step();
        check_value("unfrz_pc2a", inst_pc, 32'h2a);
        check_value("unfrz_fetch_pc", cache_addr, 32'h2c);

        // Flush coinciding with a hit discards the hit.
        flush_in = 1'b1;
        flush_pc = 32'h40;
        step();
        flush_in = 1'b0;
        check_value("flushhit_valid", {31'h0, inst_valid}, 32'h0);
        check_value("flushhit_pc", cache_addr, 32'h40);

        // Flush while a miss to 0x40 is outstanding.
        mem_lat = 6;
        cache_mem[32'h200] = 32'h0000_0013;
        seen_pc40 = 1'b0;
        step();
        check_value("miss40_req", {31'h0, mem_req}, 32'h1);
        check_value("miss40_addr", mem_addr, 32'h40);
        flush_in = 1'b1;
        flush_pc = 32'h200;
        step();
        flush_in = 1'b0;
        begin
            int u0;
            u0 = upd_cnt;
            check_value("miss40_redirect_pc", cache_addr, 32'h200);
            check_value("miss40_req_held", {31'h0, mem_req}, 32'h1);
            check_value("miss40_addr_held", mem_addr, 32'h40);
            for (int i = 0; i < 40 && !cache_upd; i++) step();
            check_value("miss40_upd_seen", {31'h0, cache_upd}, 32'h1);
            check_value("miss40_upd_addr", cache_upd_addr, 32'h40);
            wait_valid("hit200_timeout");
            check_value("hit200_pc", inst_pc, 32'h200);
            check_value("hit200_inst", inst_out, 32'h0000_0013);
            check_value("no_issue_40", {31'h0, seen_pc40}, 32'h0);
            check_value("miss40_upd_count", upd_cnt - u0, 1);
        end

        // Reset in the middle of a miss drops the request at once.
        step();
        check_value("miss204_req", {31'h0, mem_req}, 32'h1);
        check_value("miss204_addr", mem_addr, 32'h204);
        rst_in = 1'b0;
        #1;
        check_value("rstmid_req", {31'h0, mem_req}, 32'h0);
        check_value("rstmid_valid", {31'h0, inst_valid}, 32'h0);
        check_value("rstmid_pc", cache_addr, 32'h0);
        check_value("rstmid_addr", mem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
